note_sequencer: RTL and testbench
=================================

# note_sequencer

Song playback sequencer for the music generator. Walks a song memory of packed note/duration entries, holds each note for its programmed number of beats, and drives the 5-bit note select `S` consumed by the tone-select mux, plus a `note_on` gate. It sits between the song ROM and the tone mux, and it is the only block that produces `S`.

## Interface
- `TICKS_PER_BEAT`, 6250000: clk cycles per beat. Legal range ≥2; benches use 4.
- `ADDR_W`, 5: song memory address width. The song holds up to 2**ADDR_W entries.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins playback at address 0.
- `stop`  in  1  one-cycle pulse; aborts playback.
- `loop`  in  1  level, sampled at the end-of-song marker; 1 = restart at address 0.
- `song_addr`  out  ADDR_W  song memory read address.
- `song_data`  in  8  song entry. Valid one cycle after `song_addr` (synchronous ROM). Fields: [4:0] note code, [7:5] duration-1 in beats.
- `S`  out  5  note select to the tone mux.
- `note_on`  out  1  high while a note is sounding.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a non-looping song ends.

## Operation
- States: IDLE, ADDR, DATA, HOLD.
- IDLE: `S`=0, `note_on`=0, `song_addr`=0. `start` moves to ADDR with address pointer 0.
- ADDR: drives `song_addr` = pointer, then goes to DATA.
- DATA: `song_data` is valid. The block decodes it in this state:
  - Note code 5'h1F (end marker), `loop`=1: pointer ← 0, go to ADDR. `S` and `note_on` keep their values.
  - Note code 5'h1F, `loop`=0: go to IDLE, `S` ← 0, `note_on` ← 0, pulse `done`.
  - Note code 5'h00 (rest): `S` ← 0, `note_on` ← 0, go to HOLD.
  - Any other code: `S` ← code, `note_on` ← 1, go to HOLD.
  - In the rest and note cases, the duration counter loads (song_data[7:5]+1) beats and the tick counter clears.
- HOLD: the tick counter runs 0..TICKS_PER_BEAT-1. On wrap, the beat counter decrements. When the last beat wraps, pointer ← pointer+1 (modulo 2**ADDR_W; wrap to 0 is legal and silent) and the block goes to ADDR.
- During ADDR/DATA between notes, `S`/`note_on` hold the previous note. There is no glitch or gap at the mux.
- `stop` in any non-IDLE state: go to IDLE next edge, `S`=0, `note_on`=0. No `done`.
- `start` while busy: restart from address 0 (go to ADDR, counters cleared). The current note holds until the new first entry is decoded.
- `start` and `stop` in the same cycle: `stop` wins.
- Counter widths: tick counter is clog2(TICKS_PER_BEAT); beat counter is 4 bits. Neither counter saturates; both reload only in DATA.

## Timing
- Reset values: state IDLE, `S`=0, `note_on`=0, `busy`=0, `done`=0, `song_addr`=0, both counters 0.
- `start` sampled at edge E: at edge E+1 the state is ADDR. `song_data` is valid during DATA. `S`/`note_on` update at edge E+3.
- Each entry occupies exactly (dur+1)·TICKS_PER_BEAT + 2 cycles between successive `S` updates. The 2 cycles are ADDR and DATA.
- End marker adds 2 cycles: with `loop`=1, the previous note is extended by 2 cycles. With `loop`=0, IDLE, `done`=1, and `S`=0 all appear at the same edge, and `done` is high for exactly one cycle.
- `stop` at edge E: `busy`/`note_on` are 0 after E+1.
- Asynchronous `reset` mid-note forces all reset values immediately. Playback does not resume after reset deasserts.

## Test plan
- TICKS_PER_BEAT=4; ROM {0x23, 0x05, 0x1F}, `loop`=0; `start` → `S`=3 with `note_on`=1 for 10 cycles, then `S`=5 for 6 cycles, then `done` pulses once, `S`=0, `busy`=0.
- Same ROM with `loop`=1 → sequence 3,5,3,5 repeats. `S`=5 lasts 8 cycles before returning to 3. `done` never pulses.
- ROM {0x42, 0x00, 0x07, 0x1F} → `S`=2 for 14 cycles, then rest (`S`=0, `note_on`=0) for 6 cycles, then `S`=7.
- `stop` pulse 5 cycles into a note → `note_on`=0 and `busy`=0 the next cycle, no `done`. A following `start` replays from address 0.
- `start` and `stop` pulsed in the same cycle while playing → IDLE. `start` mid-note → next `S` is the entry at address 0 after 2 cycles.
- `reset` asserted asynchronously mid-HOLD → all outputs 0 without a clock edge. The block stays IDLE after release until `start`.

Source files
------------

// File: rtl/note_sequencer.sv
// Song playback sequencer: walks packed note/duration entries from a synchronous song ROM
// and drives the tone-mux note select S plus the note_on gate.
module note_sequencer #(
    parameter int TICKS_PER_BEAT = 6250000,
    parameter int ADDR_W         = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] song_addr,
    input  logic [7:0]        song_data,
    output logic [4:0]        S,
    output logic              note_on,
    output logic              busy,
    output logic              done
);
    // state | meaning
    // IDLE  | stopped, S/note_on silent, address parked at 0
    // ADDR  | song_addr presented to the ROM
    // DATA  | song_data valid, entry decoded
    // HOLD  | note or rest sounding, counting beats
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    localparam int TW = $clog2(TICKS_PER_BEAT);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [4:0]    END_MARK  = 5'h1F;

    state_t        state;
    logic [TW-1:0] tick;
    logic [3:0]    beats;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            song_addr <= '0;
            S         <= '0;
            note_on   <= 1'b0;
            done      <= 1'b0;
            tick      <= '0;
            beats     <= '0;
        end else begin
            done <= 1'b0;
            if (stop && state != IDLE) begin
                state     <= IDLE;
                song_addr <= '0;
                S         <= '0;
                note_on   <= 1'b0;
                tick      <= '0;
                beats     <= '0;
            end else if (start && !stop) begin
                // S/note_on keep the current note until the first entry is decoded
                state     <= ADDR;
                song_addr <= '0;
                tick      <= '0;
                beats     <= '0;
            end else begin
                case (state)
                    ADDR: state <= DATA;
                    DATA: begin
                        if (song_data[4:0] == END_MARK) begin
                            song_addr <= '0;
                            if (loop) begin
                                state <= ADDR;
                            end else begin
                                state   <= IDLE;
                                S       <= '0;
                                note_on <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            S       <= song_data[4:0];
                            note_on <= |song_data[4:0];
                            beats   <= {1'b0, song_data[7:5]} + 4'd1;
                            tick    <= '0;
                            state   <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            beats <= beats - 4'd1;
                            if (beats == 4'd1) begin
                                song_addr <= song_addr + ADDR_W'(1);
                                state     <= ADDR;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: segment-level playback model vs. per-cycle outputs.
module tb_note_sequencer;
    localparam int T = 4;

    typedef struct {
        logic [4:0] s;
        logic       on;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [4:0] song_addr;
    logic [7:0] song_data;
    logic [4:0] S;
    logic       note_on, busy, done;

    logic [7:0] rom [32];
    exp_t       exp_q [$];
    int         checks = 0;
    int         failures = 0;

    note_sequencer #(.TICKS_PER_BEAT(T), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .song_addr(song_addr), .song_data(song_data),
        .S(S), .note_on(note_on), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) song_data <= rom[song_addr];

    task automatic push_n(input logic [4:0] s, input logic on, input logic b, input logic d, input int n);
        exp_t e;
        e.s = s; e.on = on; e.busy = b; e.done = d;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Expected per-cycle outputs from the cycle after start is sampled: each entry sounds for
    // (dur+1) beats plus the 2 fetch cycles of the following entry.
    task automatic build_model(input logic [4:0] ps, input logic pon, input logic lp, input int cap);
        logic [4:0] cs;
        logic       con;
        int         ptr;
        logic [7:0] e;
        exp_q.delete();
        cs = ps; con = pon; ptr = 0;
        push_n(cs, con, 1'b1, 1'b0, 2);
        while (exp_q.size() < cap) begin
            e = rom[ptr];
            if (e[4:0] == 5'h1F) begin
                if (lp) begin
                    push_n(cs, con, 1'b1, 1'b0, 2);
                    ptr = 0;
                end else begin
                    push_n(5'd0, 1'b0, 1'b0, 1'b1, 1);
                    push_n(5'd0, 1'b0, 1'b0, 1'b0, 2);
                    break;
                end
            end else begin
                cs  = e[4:0];
                con = (e[4:0] != 5'd0);
                push_n(cs, con, 1'b1, 1'b0, (int'(e[7:5]) + 1) * T + 2);
                ptr = (ptr + 1) % 32;
            end
        end
        while (exp_q.size() > cap) void'(exp_q.pop_back());
    endtask

    task automatic check_run(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({S, note_on, busy, done} !== {exp_q[i].s, exp_q[i].on, exp_q[i].busy, exp_q[i].done}) begin
                failures++;
                $display("FAIL %s cycle %0d: got S=%0d on=%b busy=%b done=%b, want S=%0d on=%b busy=%b done=%b",
                         name, i, S, note_on, busy, done, exp_q[i].s, exp_q[i].on, exp_q[i].busy, exp_q[i].done);
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic stop_now();
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_rom(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        for (int i = 0; i < 32; i++) rom[i] = 8'h1F;
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({S, note_on, busy, done, song_addr} !== 13'd0) begin
                failures++;
                $display("FAIL %s: got S=%0d on=%b busy=%b done=%b addr=%0d, want all 0",
                         name, S, note_on, busy, done, song_addr);
                break;
            end
        end
    endtask

    task automatic test_reset();
        load_rom(8'h23, 8'h05, 8'h1F, 8'h1F);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle("reset_values", 3);
    endtask

    task automatic test_plan_song();
        int ndone;
        load_rom(8'h23, 8'h05, 8'h1F, 8'h1F);
        loop = 1'b0;
        build_model(5'd0, 1'b0, 1'b0, 1000);
        ndone = 0;
        foreach (exp_q[i]) ndone += int'(exp_q[i].done);
        pulse_start();
        check_run("plan_song");
        checks++;
        if (exp_q.size() != 2 + 10 + 6 + 3 || ndone != 1) begin
            failures++;
            $display("FAIL plan_model_shape: got len=%0d done=%0d, want 21 and 1", exp_q.size(), ndone);
        end
    endtask

    task automatic test_loop();
        load_rom(8'h23, 8'h05, 8'h1F, 8'h1F);
        loop = 1'b1;
        build_model(5'd0, 1'b0, 1'b1, 70);
        pulse_start();
        check_run("loop_song");
        stop_now();
        loop = 1'b0;
        check_idle("loop_stopped", 3);
    endtask

    task automatic test_rest();
        load_rom(8'h42, 8'h00, 8'h07, 8'h1F);
        build_model(5'd0, 1'b0, 1'b0, 1000);
        pulse_start();
        check_run("rest_song");
    endtask

    task automatic test_random();
        int len;
        logic lp;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) rom[i] = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 30))};
            len = $urandom_range(1, 8);
            rom[len] = {3'($urandom_range(0, 7)), 5'h1F};
            lp = r[0];
            loop = lp;
            build_model(5'd0, 1'b0, lp, lp ? 150 : 1000);
            pulse_start();
            check_run($sformatf("random_%0d", r));
            if (lp) stop_now();
            loop = 1'b0;
        end
        check_idle("random_idle", 2);
    endtask

    task automatic test_stop();
        load_rom(8'h63, 8'h05, 8'h1F, 8'h1F);
        pulse_start();
        repeat (7) @(negedge clk);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        check_idle("stop_mid_note", 6);
        build_model(5'd0, 1'b0, 1'b0, 1000);
        pulse_start();
        check_run("replay_after_stop");
    endtask

    task automatic test_start_stop_same();
        load_rom(8'h63, 8'h05, 8'h1F, 8'h1F);
        pulse_start();
        repeat (6) @(negedge clk);
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        check_idle("start_stop_same", 5);
    endtask

    task automatic test_back_to_back();
        load_rom(8'h69, 8'h2B, 8'h1F, 8'h1F);
        pulse_start();
        repeat (7) @(negedge clk);
        build_model(5'd9, 1'b1, 1'b0, 1000);
        pulse_start();
        check_run("restart_mid_note");
    endtask

    task automatic test_async_reset();
        load_rom(8'hE4, 8'h1F, 8'h1F, 8'h1F);
        pulse_start();
        repeat (8) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({S, note_on, busy, done, song_addr} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got S=%0d on=%b busy=%b done=%b addr=%0d, want all 0",
                     S, note_on, busy, done, song_addr);
        end
        @(negedge clk); reset = 1'b0;
        check_idle("after_reset_release", 10);
    endtask

    initial begin
        test_reset();
        test_plan_song();
        test_loop();
        test_rest();
        test_stop();
        test_start_stop_same();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want completion before time limit");
        $fatal(1);
    end
endmodule
